intra_angle_param_gen: RTL
==========================

# intra_angle_param_gen

Parametrised, pipelined successor to the combinational mode-to-angle lookup in the intra prediction path. It accepts one prediction command (mode, block size) through a valid/ready handshake. It then streams one beat per prediction row or column: the HEVC reference offset `iIdx`, the interpolation fraction `iFact`, the intra angle and the inverse angle. The stream feeds the reference-sample projection and angular filter stages.

## Interface
- `MAX_LOG2_SIZE`, default 5: largest supported block, as log2 of the size (5 means 32x32).
- `IDX_W`, default `MAX_LOG2_SIZE+2`: width of the signed `out_idx`.
- `POS_W`, default `MAX_LOG2_SIZE+7`: width of the signed internal position accumulator.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  command valid.
- `in_ready`  out  1  block idle and able to accept a command.
- `in_mode`  in  6  intra mode, 0..34.
- `in_log2size`  in  3  log2 of block size.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_row`  out  MAX_LOG2_SIZE  row/column index of this beat, 0..N-1.
- `out_idx`  out  IDX_W signed  `((row+1)*angle) >>> 5`.
- `out_fact`  out  5  `((row+1)*angle) & 31`.
- `out_angle`  out  7 signed  intra angle, -32..32.
- `out_inv_angle`  out  13 signed  inverse angle; 0 unless angle < 0.
- `out_is_ver`  out  1  mode 18..34.
- `out_is_ang`  out  1  mode 2..34.
- `out_last`  out  1  final beat of the command.

## Operation
- Mode classes:
  - DC/planar: mode < 2.
  - Horizontal: mode 2..17, `angleIdx = 10 - mode`.
  - Vertical: mode 18..34, `angleIdx = mode - 26`.
  - Mode > 34: treated as mode 0.
- Angle table, for `angleIdx` 0..8: 0, 2, 5, 9, 13, 17, 21, 26, 32. Negative `angleIdx` takes the negated value. Non-angular modes use angle 0.
- Inverse-angle table, for angle -2, -5, -9, -13, -17, -21, -26, -32: -4096, -1638, -910, -630, -482, -390, -315, -256. For any other angle the inverse angle is 0.
- Block size: `N = 1 << clamp(in_log2size, 2, MAX_LOG2_SIZE)`. Out-of-range sizes are clamped, never rejected.
- FSM states:
  - IDLE: `in_ready=1`. On `in_valid & in_ready`, the following are registered and the FSM goes to RUN:
    - mode class, angle, inverse angle and N;
    - accumulator set to angle;
    - row set to 0.
  - RUN: `out_valid=1`. On `out_valid & out_ready`:
    - if row = N-1, go to IDLE;
    - otherwise row += 1 and accumulator += angle.
- No multiplier:
  - the position is accumulated in a POS_W signed register;
  - `out_idx` is the arithmetic shift right by 5 (floor);
  - `out_fact` is the low 5 bits.
- `out_last = (row == N-1)` while in RUN.
- Non-angular commands still emit N beats, with idx=0, fact=0, angle=0, `is_ang=0`.
- All `out_*` data fields are registered and held stable while `out_valid & !out_ready`.
- Commands are never dropped. Commands are not accepted in RUN: `in_ready=0`.

## Timing
- Reset:
  - while `rst=1`, every output is 0, including `in_ready`;
  - in the first cycle after `rst` deasserts, the FSM is in IDLE with `in_ready=1`;
  - all other outputs remain 0 until a command is accepted.
- Latency: a command accepted in cycle T gives the first `out_valid` in cycle T+1 (row 0).
- Throughput: with `out_ready` held at 1, a command produces N consecutive beats in cycles T+1..T+N.
- After the last beat's handshake in cycle T+N, `in_ready=1` in cycle T+N+1. The next command therefore costs one idle cycle; this gap is accepted.
- Backpressure: the row and accumulator advance only on a handshake. A stall of any length preserves every output bit.
- Reset mid-burst: synchronous `rst` aborts the command immediately. Outputs go to 0 next cycle and no further beats of that command are issued.
- `in_valid` without `in_ready` has no effect. `in_mode` and `in_log2size` are sampled only on the accepting edge.

## Test plan
- Mode 26, log2size 2, `out_ready=1` -> 4 beats in cycles T+1..T+4 with angle 0, idx 0, fact 0, `is_ver=1`, `is_ang=1`, `inv_angle=0`, last on row 3; `in_ready` high at T+5.
- Mode 11, log2size 2 -> angle -2, `inv_angle` -4096, `is_ver=0`; idx -1,-1,-1,-1; fact 30,28,26,24.
- Mode 21, log2size 5 -> angle -17, `inv_angle` -482; row 0: idx -1, fact 15; row 31: idx -17, fact 0; 32 beats.
- Mode 34, log2size 3, `out_ready` toggled in a pseudo-random pattern -> idx 1..8, fact 0, angle 32, no beat lost or duplicated, outputs stable during stalls.
- Mode 1, and separately mode 40 with log2size 7 -> 32 beats, all fields 0 except row/last, `is_ang=0`.
- `rst` pulsed during row 5 of a mode-2 size-16 command -> outputs 0 the next cycle, `in_ready=1` the cycle after `rst` falls; a new mode-18 command then yields angle -32, `inv_angle` -256, idx starting at -1.

Source files
------------

// File: rtl/intra_angle_param_gen_if.sv
// Command/beat bundle for the intra angle parameter generator.
// The slave modport is the generator side; the master modport is the
// command producer plus the downstream beat consumer.
interface intra_angle_param_gen_if #(
    parameter int MAX_LOG2_SIZE = 5,
    parameter int IDX_W         = MAX_LOG2_SIZE + 2
);
    logic                          in_valid;
    logic                          in_ready;
    logic [5:0]                    in_mode;
    logic [2:0]                    in_log2size;
    logic                          out_valid;
    logic                          out_ready;
    logic [MAX_LOG2_SIZE-1:0]      out_row;
    logic signed [IDX_W-1:0]       out_idx;
    logic [4:0]                    out_fact;
    logic signed [6:0]             out_angle;
    logic signed [12:0]            out_inv_angle;
    logic                          out_is_ver;
    logic                          out_is_ang;
    logic                          out_last;

    modport master (
        output in_valid, in_mode, in_log2size, out_ready,
        input  in_ready, out_valid, out_row, out_idx, out_fact, out_angle,
               out_inv_angle, out_is_ver, out_is_ang, out_last
    );

    modport slave (
        input  in_valid, in_mode, in_log2size, out_ready,
        output in_ready, out_valid, out_row, out_idx, out_fact, out_angle,
               out_inv_angle, out_is_ver, out_is_ang, out_last
    );
endinterface

// File: rtl/intra_angle_param_gen.sv
// Intra angle parameter generator: accepts one (mode, size) command and
// streams one beat per prediction row/column carrying iIdx, iFact, the intra
// angle and the inverse angle. Positions are accumulated, not multiplied.
module intra_angle_param_gen #(
    parameter int MAX_LOG2_SIZE = 5,
    parameter int IDX_W         = MAX_LOG2_SIZE + 2,
    parameter int POS_W         = MAX_LOG2_SIZE + 7
) (
    input  logic                   clk,
    input  logic                   rst,
    intra_angle_param_gen_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [2:0]             MAX_L2 = 3'(MAX_LOG2_SIZE);
    localparam logic [MAX_LOG2_SIZE:0] N_ONE  = {{MAX_LOG2_SIZE{1'b0}}, 1'b1};

    // Angle magnitude for |angleIdx| 0..8.
    function automatic logic [5:0] angle_mag(input logic [6:0] a);
        case (a)
            7'd0:    angle_mag = 6'd0;
            7'd1:    angle_mag = 6'd2;
            7'd2:    angle_mag = 6'd5;
            7'd3:    angle_mag = 6'd9;
            7'd4:    angle_mag = 6'd13;
            7'd5:    angle_mag = 6'd17;
            7'd6:    angle_mag = 6'd21;
            7'd7:    angle_mag = 6'd26;
            7'd8:    angle_mag = 6'd32;
            default: angle_mag = 6'd0;
        endcase
    endfunction

    // Inverse angle for a negative angle of the given magnitude.
    function automatic logic signed [12:0] inv_of_mag(input logic [5:0] m);
        case (m)
            6'd2:    inv_of_mag = 13'sh1000;      // -4096
            6'd5:    inv_of_mag = -13'sd1638;
            6'd9:    inv_of_mag = -13'sd910;
            6'd13:   inv_of_mag = -13'sd630;
            6'd17:   inv_of_mag = -13'sd482;
            6'd21:   inv_of_mag = -13'sd390;
            6'd26:   inv_of_mag = -13'sd315;
            6'd32:   inv_of_mag = -13'sd256;
            default: inv_of_mag = 13'sd0;
        endcase
    endfunction

    state_t                      state_r, state_s;
    logic [MAX_LOG2_SIZE-1:0]    row_r, nm1_r, row_inc_s, nm1_s;
    logic signed [POS_W-1:0]     pos_r;
    logic signed [6:0]           angle_r, angle_s, aidx_s;
    logic signed [12:0]          inv_r, inv_s;
    logic                        ver_r, ang_r, last_r, ver_s, ang_s;
    logic [5:0]                  mode_s, mag_s;
    logic [6:0]                  aabs_s;
    logic [2:0]                  l2_s;
    logic [MAX_LOG2_SIZE:0]      n_s;
    logic                        in_ready_s, accept_s, fire_s;

    assign in_ready_s = (state_r == S_IDLE) && !rst;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign fire_s     = (state_r == S_RUN) && bus.out_ready;
    assign row_inc_s  = row_r + {{(MAX_LOG2_SIZE-1){1'b0}}, 1'b1};

    // Decode the incoming mode into class, angle and inverse angle.
    always_comb begin
        mode_s = (bus.in_mode > 6'd34) ? 6'd0 : bus.in_mode;
        ver_s  = 1'b0;
        ang_s  = 1'b0;
        aidx_s = 7'sd0;
        if (mode_s < 6'd2) begin
            ver_s  = 1'b0;
            ang_s  = 1'b0;
            aidx_s = 7'sd0;
        end else if (mode_s < 6'd18) begin
            ang_s  = 1'b1;
            aidx_s = 7'sd10 - $signed({1'b0, mode_s});
        end else begin
            ver_s  = 1'b1;
            ang_s  = 1'b1;
            aidx_s = $signed({1'b0, mode_s}) - 7'sd26;
        end
        aabs_s  = aidx_s[6] ? 7'(-aidx_s) : 7'(aidx_s);
        mag_s   = angle_mag(aabs_s);
        angle_s = aidx_s[6] ? -$signed({1'b0, mag_s}) : $signed({1'b0, mag_s});
        inv_s   = aidx_s[6] ? inv_of_mag(mag_s) : 13'sd0;
    end

    // Clamp the requested size and derive N-1.
    always_comb begin
        if (bus.in_log2size < 3'd2) begin
            l2_s = 3'd2;
        end else if (bus.in_log2size > MAX_L2) begin
            l2_s = MAX_L2;
        end else begin
            l2_s = bus.in_log2size;
        end
        n_s   = N_ONE << l2_s;
        nm1_s = MAX_LOG2_SIZE'(n_s - N_ONE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_s = S_RUN;
                else          state_s = S_IDLE;
            end
            S_RUN: begin
                if (fire_s && last_r) state_s = S_IDLE;
                else                  state_s = S_RUN;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Command capture and per-beat row/position advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r   <= {MAX_LOG2_SIZE{1'b0}};
            nm1_r   <= {MAX_LOG2_SIZE{1'b0}};
            pos_r   <= {POS_W{1'b0}};
            angle_r <= 7'sd0;
            inv_r   <= 13'sd0;
            ver_r   <= 1'b0;
            ang_r   <= 1'b0;
            last_r  <= 1'b0;
        end else if (accept_s) begin
            row_r   <= {MAX_LOG2_SIZE{1'b0}};
            nm1_r   <= nm1_s;
            pos_r   <= {{(POS_W-7){angle_s[6]}}, angle_s};
            angle_r <= angle_s;
            inv_r   <= inv_s;
            ver_r   <= ver_s;
            ang_r   <= ang_s;
            last_r  <= (nm1_s == {MAX_LOG2_SIZE{1'b0}});
        end else if (fire_s && !last_r) begin
            row_r  <= row_inc_s;
            pos_r  <= pos_r + {{(POS_W-7){angle_r[6]}}, angle_r};
            last_r <= (row_inc_s == nm1_r);
        end else if (fire_s) begin
            // final handshake: drop last, data fields hold their values
            last_r <= 1'b0;
        end else begin
            last_r <= last_r;
        end
    end

    assign bus.in_ready      = in_ready_s;
    assign bus.out_valid     = (state_r == S_RUN);
    assign bus.out_row       = row_r;
    assign bus.out_idx       = IDX_W'(pos_r >>> 5);
    assign bus.out_fact      = pos_r[4:0];
    assign bus.out_angle     = angle_r;
    assign bus.out_inv_angle = inv_r;
    assign bus.out_is_ver    = ver_r;
    assign bus.out_is_ang    = ang_r;
    assign bus.out_last      = last_r;

endmodule
